// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types and build-time switches for the basic-circuit library.
// Also provides the instantiation macro for the skid register slice.
package zion_basic_circuit_lib_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // A parameter-check failure also aborts elaboration when set.
  localparam bit CHECK_ERR_EXIT = 1'b1;

endpackage

`ifndef ZION_BASIC_CIRCUIT_LIB_SKID_DFF_MACRO
`define ZION_BASIC_CIRCUIT_LIB_SKID_DFF_MACRO
`define ZION_BASIC_CIRCUIT_LIB_SKID_DFF(inst_name, clk_s, rst_s, ivld_s, ordy_s, idat_s, ovld_s, irdy_s, odat_s, ini_s) \
  zion_basic_circuit_lib_skid_dff #( \
    .WIDTH_IN ($bits(idat_s)), \
    .WIDTH_OUT($bits(odat_s)), \
    .INI_DATA (ini_s) \
  ) inst_name ( \
    .clk (clk_s), \
    .rst (rst_s), \
    .iVld(ivld_s), \
    .oRdy(ordy_s), \
    .iDat(idat_s), \
    .oVld(ovld_s), \
    .iRdy(irdy_s), \
    .oDat(odat_s) \
  )
`endif

// File: rtl/zion_basic_circuit_lib_en_sdff.sv
// Enable DFF with synchronous active-high reset to a fixed initial value.
module zion_basic_circuit_lib_en_sdff #(
  parameter int unsigned           WIDTH    = 1,
  parameter logic [WIDTH-1:0]      INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat <= INI_DATA;
    end else if (i_en) begin
      r_dat <= i_dat;
    end
  end

  assign o_dat = r_dat;

endmodule

// File: rtl/zion_basic_circuit_lib_skid_dff.sv
// Two-entry valid/ready register slice: main register drives the output,
// skid register absorbs the one beat that arrives while oRdy is falling.
module zion_basic_circuit_lib_skid_dff
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int unsigned          WIDTH_IN  = 1,
  parameter int unsigned          WIDTH_OUT = WIDTH_IN,
  parameter logic [WIDTH_IN-1:0]  INI_DATA  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iVld,
  output logic                 oRdy,
  input  logic [WIDTH_IN-1:0]  iDat,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [WIDTH_OUT-1:0] oDat
);

  if (WIDTH_IN != WIDTH_OUT) begin : g_width_err
    $error("zion_basic_circuit_lib_skid_dff: WIDTH_IN (%0d) != WIDTH_OUT (%0d)", WIDTH_IN, WIDTH_OUT);
    if (CHECK_ERR_EXIT) begin : g_exit
      $fatal(1, "zion_basic_circuit_lib_skid_dff: aborting on parameter error");
    end
  end

  skid_state_e         r_state;
  skid_state_e         w_state_nxt;
  logic                r_rdy;
  logic                w_in;
  logic                w_out;
  logic                w_main_en;
  logic                w_skid_en;
  logic                w_main_from_skid;
  logic [WIDTH_IN-1:0] w_main_d;
  logic [WIDTH_IN-1:0] w_main_q;
  logic [WIDTH_IN-1:0] w_skid_q;

  assign oVld  = (r_state != EMPTY);
  assign oRdy  = r_rdy;
  assign w_in  = iVld & r_rdy;
  assign w_out = oVld & iRdy;

  // Next-state and register-load decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in) begin
          w_main_en   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_in && w_out) begin
          w_main_en = 1'b1;
        end else if (w_in) begin
          w_skid_en   = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out) begin
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // oRdy is registered from the next state so it never depends on iRdy combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt != FULL);
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : iDat;

  zion_basic_circuit_lib_en_sdff #(
    .WIDTH   (WIDTH_IN),
    .INI_DATA(INI_DATA)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_main_en),
    .i_dat(w_main_d),
    .o_dat(w_main_q)
  );

  zion_basic_circuit_lib_en_sdff #(
    .WIDTH   (WIDTH_IN),
    .INI_DATA(INI_DATA)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_skid_en),
    .i_dat(iDat),
    .o_dat(w_skid_q)
  );

  assign oDat = WIDTH_OUT'(w_main_q);

endmodule

// File: tb/tb_zion_basic_circuit_lib_skid_dff.sv
// Scoreboard bench for the skid register slice: beats are queued on input
// handshakes and checked in order on output handshakes.
module tb_zion_basic_circuit_lib_skid_dff;

  localparam int unsigned W   = 8;
  localparam logic [W-1:0] INI = 8'h5C;

  logic         clk;
  logic         rst;
  logic         iVld;
  logic         oRdy;
  logic [W-1:0] iDat;
  logic         oVld;
  logic         iRdy;
  logic [W-1:0] oDat;

  int unsigned  n_chk;
  int unsigned  n_bad;
  int unsigned  n_out;
  logic [W-1:0] q[$];
  logic         rst_prev;
  logic         stall_prev;
  logic [W-1:0] dat_prev;
  logic         ini_expect;

  zion_basic_circuit_lib_skid_dff #(
    .WIDTH_IN (W),
    .WIDTH_OUT(W),
    .INI_DATA (INI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .iVld(iVld),
    .oRdy(oRdy),
    .iDat(iDat),
    .oVld(oVld),
    .iRdy(iRdy),
    .oDat(oDat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge against the model, update the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic rs,
                      output logic acc);
    iVld = v;
    iDat = d;
    iRdy = r;
    rst  = rs;
    acc  = 1'b0;
    @(negedge clk);
    check_eq("ovld", 32'(oVld), 32'(q.size() != 0));
    check_eq("ordy", 32'(oRdy), 32'(!rst_prev && (q.size() < 2)));
    if (stall_prev) check_eq("hold", 32'(oDat), 32'(dat_prev));
    if (ini_expect) check_eq("odat_ini", 32'(oDat), 32'(INI));
    if (rs) begin
      q.delete();
      ini_expect = 1'b1;
    end else begin
      if (oVld && iRdy) begin
        n_out++;
        check_eq("q_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check_eq("odat", 32'(oDat), 32'(q.pop_front()));
      end
      if (iVld && oRdy) begin
        q.push_back(iDat);
        acc        = 1'b1;
        ini_expect = 1'b0;
      end
    end
    stall_prev = !rs && oVld && !iRdy;
    dat_prev   = oDat;
    rst_prev   = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic         acc;
    logic         cur_v;
    logic [W-1:0] cur_d;
    logic [W-1:0] seq_d;
    int unsigned  out0;

    n_chk = 0; n_bad = 0; n_out = 0;
    rst_prev = 1'b1; stall_prev = 1'b0; dat_prev = '0; ini_expect = 1'b1;
    rst = 1'b1; iVld = 1'b1; iDat = 8'hAA; iRdy = 1'b0;
    @(posedge clk);
    #1;

    // Reset with a live upstream beat: nothing captured, oRdy held low.
    step(1'b1, 8'hAA, 1'b1, 1'b1, acc);
    step(1'b1, 8'hAA, 1'b1, 1'b1, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Back-to-back streaming.
    out0 = n_out;
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_eq("stream_outs", n_out - out0, 32'd16);

    // Stall fill: 0x23 must wait upstream until the slice drains.
    step(1'b1, 8'h21, 1'b0, 1'b0, acc);
    step(1'b1, 8'h22, 1'b0, 1'b0, acc);
    step(1'b1, 8'h23, 1'b0, 1'b0, acc);
    check_eq("stall_23_held", 32'(acc), 32'd0);
    step(1'b1, 8'h23, 1'b0, 1'b0, acc);
    step(1'b1, 8'h23, 1'b1, 1'b0, acc);
    step(1'b1, 8'h23, 1'b1, 1'b0, acc);
    check_eq("stall_23_acc", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Random valid/ready with upstream holding unaccepted beats.
    cur_v = 1'b0; cur_d = '0; seq_d = 8'h40; acc = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!cur_v || acc) begin
        cur_v = 1'($urandom_range(0, 1));
        cur_d = seq_d;
        if (cur_v) seq_d = seq_d + 8'd1;
      end
      step(cur_v, cur_d, 1'($urandom_range(0, 1)), 1'b0, acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_eq("rand_drained", 32'(q.size()), 32'd0);

    // Reset while FULL: held beats are discarded.
    step(1'b1, 8'h31, 1'b0, 1'b0, acc);
    step(1'b1, 8'h32, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b1, 8'h77, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
